id_scoreboard: RTL and testbench

Parametrised register-hazard scoreboard for the decode stage. It replaces the single-cycle "EX-stage load + dest match" block check. It tracks every in-flight register write between issue (ID→EX handshake) and retire (WB regfile write), and separates results that can be forwarded from "late" results (loads, multi-cycle mul/div) that cannot. It produces the decode stall, so producers of any latency and any pipeline depth are handled without changing the decoder.

---
 rtl/id_scoreboard_pkg.sv | 18 +
 rtl/id_scoreboard_if.sv | 35 +++
 rtl/id_scoreboard_sb_entry.sv | 83 ++++++++
 rtl/id_scoreboard.sv | 73 +++++++
 tb/tb_id_scoreboard.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_scoreboard_pkg.sv
// Shared defaults and types for the decode-stage register hazard scoreboard.
// Holds the per-register status bundle reported by each counter entry.
package id_scoreboard_pkg;

    localparam int DEF_REG_NUM = 32;
    localparam int DEF_AW      = 5;
    localparam int DEF_NUM_RD  = 2;
    localparam int DEF_CNT_W   = 2;

    // Status of one tracked register as seen by the stall logic.
    typedef struct packed {
        logic busy;     // at least one writer in flight
        logic sat;      // pend counter at its maximum
        logic late_blk; // late writer still in flight after WB bypass
        logic err;      // underflow or saturated issue this cycle
    } sb_stat_t;

endpackage

// File: rtl/id_scoreboard_if.sv
// Decoder/pipeline <-> scoreboard signal bundle.
// master is the pipeline side, slave is the scoreboard.
interface id_scoreboard_if #(
    parameter int REG_NUM = 32,
    parameter int AW      = 5,
    parameter int NUM_RD  = 2
);
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD-1:0]    rd_used;
    logic                 issue_fire;
    logic                 issue_we;
    logic [AW-1:0]        issue_dest;
    logic                 issue_late;
    logic                 wb_fire;
    logic [AW-1:0]        wb_dest;
    logic                 wb_late;
    logic                 flush;
    logic                 ds_stall;
    logic [REG_NUM-1:0]   busy;
    logic                 sb_err;

    modport master (
        output rd_addr, rd_used,
        output issue_fire, issue_we, issue_dest, issue_late,
        output wb_fire, wb_dest, wb_late, flush,
        input  ds_stall, busy, sb_err
    );

    modport slave (
        input  rd_addr, rd_used,
        input  issue_fire, issue_we, issue_dest, issue_late,
        input  wb_fire, wb_dest, wb_late, flush,
        output ds_stall, busy, sb_err
    );
endinterface

// File: rtl/id_scoreboard_sb_entry.sv
// One register's pending/late in-flight writer counters.
// Same-cycle issue and retire net out instead of applying in sequence.
module sb_entry
    import id_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  logic     inc,
    input  logic     inc_late,
    input  logic     dec,
    input  logic     dec_late,
    output sb_stat_t stat
);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] late_q, late_d;
    logic             pend_err, late_err;
    logic             lup, ldn;

    assign lup = inc && inc_late;
    assign ldn = dec && dec_late;

    // Next counter values with saturate/underflow holds; flush clears.
    always_comb begin
        pend_d   = pend_q;
        late_d   = late_q;
        pend_err = 1'b0;
        late_err = 1'b0;
        unique case ({inc, dec})
            2'b10: begin
                if (pend_q == CMAX) pend_err = 1'b1;
                else pend_d = pend_q + ONE;
            end
            2'b01: begin
                if (pend_q == '0) pend_err = 1'b1;
                else pend_d = pend_q - ONE;
            end
            default: ;
        endcase
        unique case ({lup, ldn})
            2'b10: begin
                if (late_q == CMAX) late_err = 1'b1;
                else late_d = late_q + ONE;
            end
            2'b01: begin
                if (late_q == '0) late_err = 1'b1;
                else late_d = late_q - ONE;
            end
            default: ;
        endcase
        if (flush) begin
            pend_d   = '0;
            late_d   = '0;
            pend_err = 1'b0;
            late_err = 1'b0;
        end
    end

    // Counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            late_q <= '0;
        end else begin
            pend_q <= pend_d;
            late_q <= late_d;
        end
    end

    // Status: a late retire this cycle is covered by the WB bypass.
    always_comb begin
        stat.busy     = (pend_q != '0);
        stat.sat      = (pend_q == CMAX);
        stat.late_blk = ldn ? (late_q > ONE) : (late_q != '0);
        stat.err      = pend_err || late_err;
    end

endmodule

// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard: tracks in-flight writers from issue to WB
// and stalls decode only on late (non-forwardable) results.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int REG_NUM = DEF_REG_NUM,
    parameter int AW      = DEF_AW,
    parameter int NUM_RD  = DEF_NUM_RD,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    id_scoreboard_if.slave sb
);
    localparam int NSLOT = 2 ** AW;

    sb_stat_t           stat [NSLOT];
    logic               stall_c;
    logic               err_c;
    logic [REG_NUM-1:0] busy_c;
    logic [AW-1:0]      src;
    logic               sb_err_q, sb_err_d;

    for (genvar r = 0; r < NSLOT; r++) begin : g_ent
        if (r >= 1 && r < REG_NUM) begin : g_trk
            logic inc, dec;
            assign inc = sb.issue_fire && sb.issue_we &&
                         (sb.issue_dest == AW'(r));
            assign dec = sb.wb_fire && (sb.wb_dest == AW'(r));
            sb_entry #(.CNT_W(CNT_W)) u_ent (
                .clk      (clk),
                .reset    (reset),
                .flush    (sb.flush),
                .inc      (inc),
                .inc_late (sb.issue_late),
                .dec      (dec),
                .dec_late (sb.wb_late),
                .stat     (stat[r])
            );
        end else begin : g_zero
            assign stat[r] = '0;
        end
    end

    // Stall, busy vector and error collection; no issue_fire dependence.
    always_comb begin
        stall_c = stat[sb.issue_dest].sat;
        src     = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            src = sb.rd_addr[i*AW +: AW];
            if (sb.rd_used[i] && src != '0)
                stall_c = stall_c | stat[src].late_blk | stat[src].sat;
        end
        err_c  = 1'b0;
        busy_c = '0;
        for (int r = 0; r < REG_NUM; r++) begin
            err_c     = err_c | stat[r].err;
            busy_c[r] = stat[r].busy;
        end
        sb_err_d = sb_err_q | err_c;
    end

    // Sticky error flag; survives flush, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sb_err_q <= 1'b0;
        else       sb_err_q <= sb_err_d;
    end

    assign sb.ds_stall = stall_c;
    assign sb.busy     = busy_c;
    assign sb.sb_err   = sb_err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: load-use, ALU, netting, r0,
// saturation/underflow, flush and asynchronous reset.
module tb_id_scoreboard;
    localparam int REG_NUM = 32;
    localparam int AW      = 5;
    localparam int NUM_RD  = 2;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    id_scoreboard_if #(.REG_NUM(REG_NUM), .AW(AW), .NUM_RD(NUM_RD)) sbif ();

    id_scoreboard #(.REG_NUM(REG_NUM), .AW(AW), .NUM_RD(NUM_RD), .CNT_W(2))
        dut (.clk(clk), .reset(reset), .sb(sbif));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sbif.rd_addr    = '0;
        sbif.rd_used    = '0;
        sbif.issue_fire = 1'b0;
        sbif.issue_we   = 1'b0;
        sbif.issue_dest = '0;
        sbif.issue_late = 1'b0;
        sbif.wb_fire    = 1'b0;
        sbif.wb_dest    = '0;
        sbif.wb_late    = 1'b0;
        sbif.flush      = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] d, input logic late);
        sbif.issue_fire = 1'b1;
        sbif.issue_we   = 1'b1;
        sbif.issue_dest = d;
        sbif.issue_late = late;
        step();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if (sbif.busy !== '0) begin
            miscompares++;
            $display("FAIL reset_busy got %h want 0", sbif.busy);
        end
        vectors++;
        if (sbif.ds_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall got %b want 0", sbif.ds_stall);
        end
        vectors++;
        if (sbif.sb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err got %b want 0", sbif.sb_err);
        end
    endtask

    task automatic test_load_use();
        issue(5'd5, 1'b1);
        sbif.rd_addr = {5'd0, 5'd5};
        sbif.rd_used = 2'b01;
        #1;
        vectors++;
        if (sbif.ds_stall !== 1'b1 || sbif.busy[5] !== 1'b1) begin
            miscompares++;
            $display("FAIL lu_stall got %b/%b want 1/1",
                     sbif.ds_stall, sbif.busy[5]);
        end
        step();
        vectors++;
        if (sbif.ds_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL lu_hold got %b want 1", sbif.ds_stall);
        end
        sbif.wb_fire = 1'b1;
        sbif.wb_dest = 5'd5;
        sbif.wb_late = 1'b1;
        #1;
        vectors++;
        if (sbif.ds_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL lu_wb_bypass got %b want 0", sbif.ds_stall);
        end
        step();
        idle();
        #1;
        vectors++;
        if (sbif.busy[5] !== 1'b0 || sbif.busy !== '0) begin
            miscompares++;
            $display("FAIL lu_release got %h want 0", sbif.busy);
        end
    endtask

    task automatic test_alu_dep();
        issue(5'd7, 1'b0);
        sbif.rd_addr = {5'd7, 5'd7};
        sbif.rd_used = 2'b11;
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++;
            if (sbif.ds_stall !== 1'b0 || sbif.busy[7] !== 1'b1) begin
                miscompares++;
                $display("FAIL alu_nostall got %b/%b want 0/1",
                         sbif.ds_stall, sbif.busy[7]);
            end
            step();
        end
        sbif.wb_fire = 1'b1;
        sbif.wb_dest = 5'd7;
        step();
        idle();
        #1;
        vectors++;
        if (sbif.busy[7] !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_retire got %b want 0", sbif.busy[7]);
        end
    endtask

    task automatic test_simultaneous();
        issue(5'd3, 1'b0);
        sbif.issue_fire = 1'b1;
        sbif.issue_we   = 1'b1;
        sbif.issue_dest = 5'd3;
        sbif.wb_fire    = 1'b1;
        sbif.wb_dest    = 5'd3;
        step();
        idle();
        vectors++;
        if (sbif.busy[3] !== 1'b1 || sbif.sb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_net got %b/%b want 1/0",
                     sbif.busy[3], sbif.sb_err);
        end
        sbif.wb_fire = 1'b1;
        sbif.wb_dest = 5'd3;
        step();
        idle();
        vectors++;
        if (sbif.busy[3] !== 1'b0 || sbif.sb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_count1 got %b/%b want 0/0",
                     sbif.busy[3], sbif.sb_err);
        end
    endtask

    task automatic test_r0_unused();
        issue(5'd0, 1'b1);
        sbif.rd_addr = {5'd0, 5'd0};
        sbif.rd_used = 2'b11;
        #1;
        vectors++;
        if (sbif.busy !== '0 || sbif.ds_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL r0 got %h/%b want 0/0",
                     sbif.busy, sbif.ds_stall);
        end
        idle();
        issue(5'd12, 1'b1);
        sbif.rd_addr = {5'd12, 5'd0};
        sbif.rd_used = 2'b01;
        #1;
        vectors++;
        if (sbif.ds_stall !== 1'b0 || sbif.busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL unused_port got %b want 0", sbif.ds_stall);
        end
        sbif.rd_used = 2'b10;
        #1;
        vectors++;
        if (sbif.ds_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL used_port1 got %b want 1", sbif.ds_stall);
        end
        idle();
        sbif.wb_fire = 1'b1;
        sbif.wb_dest = 5'd12;
        sbif.wb_late = 1'b1;
        step();
        idle();
    endtask

    task automatic test_sat_underflow();
        for (int k = 0; k < 3; k++) issue(5'd9, 1'b1);
        sbif.issue_dest = 5'd9;
        #1;
        vectors++;
        if (sbif.ds_stall !== 1'b1 || sbif.sb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_dest got %b/%b want 1/0",
                     sbif.ds_stall, sbif.sb_err);
        end
        issue(5'd9, 1'b1);
        vectors++;
        if (sbif.sb_err !== 1'b1 || sbif.busy[9] !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_err got %b want 1", sbif.sb_err);
        end
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step();
        sbif.wb_fire = 1'b1;
        sbif.wb_dest = 5'd10;
        #1;
        vectors++;
        if (sbif.sb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL uf_pre got %b want 0", sbif.sb_err);
        end
        step();
        idle();
        step();
        step();
        vectors++;
        if (sbif.sb_err !== 1'b1 || sbif.busy[10] !== 1'b0) begin
            miscompares++;
            $display("FAIL uf_sticky got %b/%b want 1/0",
                     sbif.sb_err, sbif.busy[10]);
        end
    endtask

    task automatic test_flush_reset();
        issue(5'd4, 1'b1);
        issue(5'd6, 1'b0);
        vectors++;
        if (sbif.busy[4] !== 1'b1 || sbif.busy[6] !== 1'b1) begin
            miscompares++;
            $display("FAIL fl_pre got %b%b want 11",
                     sbif.busy[4], sbif.busy[6]);
        end
        sbif.flush      = 1'b1;
        sbif.issue_fire = 1'b1;
        sbif.issue_we   = 1'b1;
        sbif.issue_dest = 5'd8;
        sbif.issue_late = 1'b1;
        sbif.wb_fire    = 1'b1;
        sbif.wb_dest    = 5'd10;
        step();
        idle();
        sbif.rd_addr = {5'd8, 5'd4};
        sbif.rd_used = 2'b11;
        #1;
        vectors++;
        if (sbif.busy !== '0 || sbif.ds_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL flush got %h/%b want 0/0",
                     sbif.busy, sbif.ds_stall);
        end
        vectors++;
        if (sbif.sb_err !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_err got %b want 1", sbif.sb_err);
        end
        idle();
        issue(5'd4, 1'b1);
        sbif.rd_addr = {5'd0, 5'd4};
        sbif.rd_used = 2'b01;
        #1;
        vectors++;
        if (sbif.ds_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre got %b want 1", sbif.ds_stall);
        end
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (sbif.busy !== '0 || sbif.ds_stall !== 1'b0 ||
            sbif.sb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL async_rst got %h/%b/%b want 0/0/0",
                     sbif.busy, sbif.ds_stall, sbif.sb_err);
        end
        reset = 1'b0;
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_dep();
        test_simultaneous();
        test_r0_unused();
        test_sat_underflow();
        test_flush_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
